xpb_lookup_sched: RTL

Sequencer that shares one precomputed-multiple lookup bank (the 5-bit xpb reduction tables) across all digit positions of a modular-square reduction. It accepts a vector of 5-bit reduction digits and issues one table lookup per digit position per cycle, skipping zero digits. It accumulates the returned 1024-bit multiples into a non-reduced sum for the downstream carry-save/reduction stage. It sits between the product splitter and the shared xpb table bank.

---
 rtl/xpb_lookup_sched.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/xpb_lookup_sched.sv
// Shares one xpb multiple-lookup bank across all digit positions of a reduction:
// issues one lookup per non-zero digit, then sums the returned multiples unreduced.
//
// state | meaning
// IDLE  | ready for a digit vector
// ISSUE | one digit position per cycle, request only for non-zero digits
// DRAIN | wait LUT_LAT cycles for the last bank return to be accumulated
// DONE  | hold out_sum until the consumer takes it
module xpb_lookup_sched #(
    parameter int WORD_BITS  = 1024,
    parameter int DIGIT_BITS = 5,
    parameter int NUM_DIGITS = 8,
    parameter int BASE_IDX   = 0,
    parameter int IDX_BITS   = 8,
    parameter int LUT_LAT    = 2,
    parameter int SUM_BITS   = WORD_BITS + $clog2(NUM_DIGITS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_DIGITS*DIGIT_BITS-1:0] in_digits,
    output logic                             lut_req,
    output logic [IDX_BITS-1:0]              lut_idx,
    output logic [DIGIT_BITS-1:0]            lut_digit,
    input  logic [WORD_BITS-1:0]             lut_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [SUM_BITS-1:0]              out_sum
);

    localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DRN_W = $clog2(LUT_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                          state_q, state_d;
    logic [CNT_W-1:0]                pos_q, pos_d;
    logic [DRN_W-1:0]                drain_q, drain_d;
    logic [NUM_DIGITS*DIGIT_BITS-1:0] digits_q, digits_d;
    logic [SUM_BITS-1:0]             acc_q, acc_d;
    logic [LUT_LAT-1:0]              ret_q, ret_d;
    logic                            lut_req_q, lut_req_d;
    logic [IDX_BITS-1:0]             lut_idx_q, lut_idx_d;
    logic [DIGIT_BITS-1:0]           lut_digit_q, lut_digit_d;
    logic [DIGIT_BITS-1:0]           cur_digit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pos_q       <= '0;
            drain_q     <= '0;
            digits_q    <= '0;
            acc_q       <= '0;
            ret_q       <= '0;
            lut_req_q   <= 1'b0;
            lut_idx_q   <= '0;
            lut_digit_q <= '0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            drain_q     <= drain_d;
            digits_q    <= digits_d;
            acc_q       <= acc_d;
            ret_q       <= ret_d;
            lut_req_q   <= lut_req_d;
            lut_idx_q   <= lut_idx_d;
            lut_digit_q <= lut_digit_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        drain_d     = drain_q;
        digits_d    = digits_q;
        acc_d       = acc_q;
        lut_req_d   = 1'b0;
        lut_idx_d   = '0;
        lut_digit_d = '0;
        cur_digit   = '0;

        // The shift register mirrors the bank pipeline; its tail marks a valid return.
        ret_d    = ret_q << 1;
        ret_d[0] = lut_req_q;
        if (ret_q[LUT_LAT-1]) begin
            acc_d = acc_q + SUM_BITS'(lut_data);
        end

        // Requests are registered, so each state prepares the request for the next cycle.
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d   = S_ISSUE;
                    digits_d  = in_digits;
                    acc_d     = '0;
                    pos_d     = '0;
                    cur_digit = in_digits[DIGIT_BITS-1:0];
                    if (cur_digit != '0) begin
                        lut_req_d   = 1'b1;
                        lut_idx_d   = IDX_BITS'(BASE_IDX);
                        lut_digit_d = cur_digit;
                    end
                end
            end
            S_ISSUE: begin
                if (pos_q == CNT_W'(NUM_DIGITS - 1)) begin
                    state_d = S_DRAIN;
                    drain_d = DRN_W'(LUT_LAT - 1);
                end else begin
                    pos_d     = pos_q + 1'b1;
                    cur_digit = digits_q[pos_d*DIGIT_BITS +: DIGIT_BITS];
                    if (cur_digit != '0) begin
                        lut_req_d   = 1'b1;
                        lut_idx_d   = IDX_BITS'(BASE_IDX) + IDX_BITS'(pos_d);
                        lut_digit_d = cur_digit;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_sum   = acc_q;
    assign lut_req   = lut_req_q;
    assign lut_idx   = lut_idx_q;
    assign lut_digit = lut_digit_q;

endmodule
